// File: rtl/vc_scheduler_pkg.sv
// rtl/vc_scheduler_pkg.sv - shared encodings and helpers for the VC scheduler
//
// Holds the scheduler state encoding, VC index constants, the credit-width
// helper and a small index-to-state conversion used by the arbiter.
package vc_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VC0  = 2'd1,
    ST_VC1  = 2'd2
  } sched_state_e;

  localparam logic VC0_IDX = 1'b0;
  localparam logic VC1_IDX = 1'b1;

  // Enough bits to hold a credit count from 0 up to the larger weight.
  function automatic int credit_width(input int w0, input int w1);
    return $clog2(((w0 > w1) ? w0 : w1) + 1);
  endfunction

  function automatic sched_state_e vc_state(input logic idx);
    return (idx == VC1_IDX) ? ST_VC1 : ST_VC0;
  endfunction

endpackage

// File: rtl/vc_scheduler_if.sv
// rtl/vc_scheduler_if.sv - handshake bundle between the VC scheduler and its neighbours
//
// master: scheduler side (takes FIFO status and active, drives pops/status).
// slave : FIFO/fsm side (drives status and active, observes pops/status).
interface vc_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             active;
  logic             fifo_empty_vc0;
  logic             fifo_empty_vc1;
  logic             dest_vc0;
  logic             dest_vc1;
  logic             fifo_pause_d0;
  logic             fifo_pause_d1;
  logic             pop_vc0;
  logic             pop_vc1;
  logic             pop_delay_vc0;
  logic             pop_delay_vc1;
  logic [1:0]       sched_state;
  logic [CNT_W-1:0] grant_cnt_vc0;
  logic [CNT_W-1:0] grant_cnt_vc1;

  modport master (
    input  active, fifo_empty_vc0, fifo_empty_vc1, dest_vc0, dest_vc1,
           fifo_pause_d0, fifo_pause_d1,
    output pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, sched_state,
           grant_cnt_vc0, grant_cnt_vc1
  );

  modport slave (
    output active, fifo_empty_vc0, fifo_empty_vc1, dest_vc0, dest_vc1,
           fifo_pause_d0, fifo_pause_d1,
    input  pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, sched_state,
           grant_cnt_vc0, grant_cnt_vc1
  );

endinterface

// File: rtl/grant_counter.sv
// rtl/grant_counter.sv - wrapping grant counter with increment enable and async clear
//
// Ports: clk_i clock, clr_i async active-high clear, en_i count this cycle,
//        count_o current count (wraps from all-ones to zero).
module grant_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vc_scheduler.sv
// rtl/vc_scheduler.sv - weighted round-robin pop scheduler for the VC0/VC1 FIFO pair
//
// Ports: clk clock, reset async active-high reset, bus (master modport):
//   in : active, fifo_empty_vc0/1, dest_vc0/1, fifo_pause_d0/1
//   out: pop_vc0/1 (combinational grant), pop_delay_vc0/1 (pop lagged one
//        cycle, mux select), sched_state, grant_cnt_vc0/1.
module vc_scheduler
  import vc_scheduler_pkg::*;
#(
  parameter int W0    = 2,
  parameter int W1    = 1,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  vc_scheduler_if.master bus
);

  localparam int CRED_W = credit_width(W0, W1);
  localparam logic [CRED_W-1:0] W0_C = CRED_W'(W0);
  localparam logic [CRED_W-1:0] W1_C = CRED_W'(W1);

  sched_state_e      state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic              pop_delay_vc0_q, pop_delay_vc1_q;

  logic [1:0]        elig;
  logic [1:0]        pop;
  logic              owner, other;
  logic [CRED_W-1:0] w_own;
  logic [CNT_W-1:0]  cnt_vc0, cnt_vc1;

  always_comb begin
    elig[VC0_IDX] = ~bus.fifo_empty_vc0 &
                    ~(bus.dest_vc0 ? bus.fifo_pause_d1 : bus.fifo_pause_d0);
    elig[VC1_IDX] = ~bus.fifo_empty_vc1 &
                    ~(bus.dest_vc1 ? bus.fifo_pause_d1 : bus.fifo_pause_d0);

    // IDLE hands the turn to VC0, which is what makes VC0 win ties from IDLE.
    owner = (state_q == ST_VC1) ? VC1_IDX : VC0_IDX;
    other = ~owner;
    w_own = (owner == VC1_IDX) ? W1_C : W0_C;

    pop      = '0;
    state_d  = ST_IDLE;
    credit_d = '0;

    // Reset gates the grant so pops drop as soon as reset rises.
    if (bus.active && !reset) begin
      if (elig[owner] && (credit_q < w_own)) begin
        pop[owner] = 1'b1;
        state_d    = vc_state(owner);
        credit_d   = credit_q + 1'b1;
      end else if (elig[other]) begin
        pop[other] = 1'b1;
        state_d    = vc_state(other);
        credit_d   = CRED_W'(1);
      end else if (elig[owner]) begin
        // Turn exhausted but nobody else wants it: start a fresh turn.
        pop[owner] = 1'b1;
        state_d    = vc_state(owner);
        credit_d   = CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      credit_q        <= '0;
      pop_delay_vc0_q <= 1'b0;
      pop_delay_vc1_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      pop_delay_vc0_q <= pop[VC0_IDX];
      pop_delay_vc1_q <= pop[VC1_IDX];
    end
  end

  grant_counter #(.CNT_W(CNT_W)) u_cnt_vc0 (
    .clk_i   (clk),
    .clr_i   (reset),
    .en_i    (pop[VC0_IDX]),
    .count_o (cnt_vc0)
  );

  grant_counter #(.CNT_W(CNT_W)) u_cnt_vc1 (
    .clk_i   (clk),
    .clr_i   (reset),
    .en_i    (pop[VC1_IDX]),
    .count_o (cnt_vc1)
  );

  assign bus.pop_vc0       = pop[VC0_IDX];
  assign bus.pop_vc1       = pop[VC1_IDX];
  assign bus.pop_delay_vc0 = pop_delay_vc0_q;
  assign bus.pop_delay_vc1 = pop_delay_vc1_q;
  assign bus.sched_state   = state_q;
  assign bus.grant_cnt_vc0 = cnt_vc0;
  assign bus.grant_cnt_vc1 = cnt_vc1;

endmodule
